red_pitaya_fads_cond: RTL and testbench

Signal conditioner placed directly upstream of the FADS droplet detector. It takes the raw channel-A ADC sample, smooths it with a power-of-two boxcar moving average, tracks and subtracts a slow baseline that freezes while a droplet passes, and saturates the result to 14-bit signed. The detector consumes the output in place of the raw ADC sample. Thresholds in the detector therefore refer to a baseline-free signal.

---
 rtl/red_pitaya_fads_pkg.sv | 29 ++
 rtl/red_pitaya_fads_cond_if.sv | 16 +
 rtl/red_pitaya_fads_boxcar.sv | 60 ++++++
 rtl/red_pitaya_fads_cond.sv | 158 +++++++++++++++
 tb/tb_red_pitaya_fads_cond.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/red_pitaya_fads_pkg.sv
// Shared definitions for the FADS signal conditioner: sample width, register map,
// conditioner state and the signed saturation helpers.
package red_pitaya_fads_pkg;

   localparam int DWT = 14;

   localparam logic [19:0] REG_CTRL = 20'h00;
   localparam logic [19:0] REG_AVG  = 20'h04;
   localparam logic [19:0] REG_BLSH = 20'h08;
   localparam logic [19:0] REG_THR  = 20'h0C;
   localparam logic [19:0] REG_BL   = 20'h10;
   localparam logic [19:0] REG_SAT  = 20'h14;

   localparam logic signed [DWT:0] SMAX = {2'b00, {(DWT-1){1'b1}}};
   localparam logic signed [DWT:0] SMIN = {2'b11, {(DWT-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

   function automatic logic is_clip(input logic signed [DWT:0] v);
      return (v > SMAX) || (v < SMIN);
   endfunction

   function automatic logic signed [DWT-1:0] sat(input logic signed [DWT:0] v);
      if (v > SMAX) return SMAX[DWT-1:0];
      if (v < SMIN) return SMIN[DWT-1:0];
      return v[DWT-1:0];
   endfunction

endpackage

// File: rtl/red_pitaya_fads_cond_if.sv
// Register bus between the system bus master and the FADS conditioner.
interface red_pitaya_fads_cond_if;
   logic [31:0] sys_addr;
   logic [31:0] sys_wdata;
   logic [3:0]  sys_sel;
   logic        sys_wen;
   logic        sys_ren;
   logic [31:0] sys_rdata;
   logic        sys_err;
   logic        sys_ack;

   modport master (output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
                   input  sys_rdata, sys_err, sys_ack);
   modport slave  (input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
                   output sys_rdata, sys_err, sys_ack);
endinterface

// File: rtl/red_pitaya_fads_boxcar.sv
// Power-of-two boxcar: delay line + running sum (stage 1), shift to average (stage 2).
// o_filled is aligned with o_avg and marks a fully averaged sample.
module red_pitaya_fads_boxcar
   import red_pitaya_fads_pkg::*;
#(
   parameter int AVG_LOG2_MAX = 4,
   parameter int LW           = $clog2(AVG_LOG2_MAX + 1)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_en,
   input  logic                  i_flush,
   input  logic [LW-1:0]         i_log2,
   input  logic signed [DWT-1:0] i_x,
   output logic signed [DWT-1:0] o_avg,
   output logic                  o_filled
);
   localparam int DEPTH = 2 ** AVG_LOG2_MAX;
   localparam int SW    = DWT + AVG_LOG2_MAX;
   localparam int CW    = AVG_LOG2_MAX + 1;

   logic signed [DWT-1:0] r_dl [DEPTH];
   logic signed [SW-1:0]  r_sum;
   logic signed [SW-1:0]  w_avg_full;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         w_len;
   logic                  r_full;
   logic signed [DWT-1:0] w_tap;
   logic                  w_unused;

   assign w_len      = CW'(1) << i_log2;
   assign w_tap      = r_dl[AVG_LOG2_MAX'(w_len - CW'(1))];
   assign w_avg_full = r_sum >>> i_log2;
   assign w_unused   = ^w_avg_full[SW-1:DWT];

   // flush has priority over the incoming sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst || i_flush) begin
         for (int i = 0; i < DEPTH; i++) r_dl[i] <= '0;
         r_sum    <= '0;
         r_cnt    <= '0;
         r_full   <= 1'b0;
         o_avg    <= '0;
         o_filled <= 1'b0;
      end else begin
         if (i_en) begin
            r_dl[0] <= i_x;
            for (int i = 1; i < DEPTH; i++) r_dl[i] <= r_dl[i-1];
            r_sum <= r_sum + SW'(i_x) - SW'(w_tap);
            if (!r_full) begin
               r_cnt  <= r_cnt + CW'(1);
               r_full <= (r_cnt == w_len - CW'(1));
            end
         end
         o_avg    <= w_avg_full[DWT-1:0];
         o_filled <= r_full;
      end
   end

endmodule

// File: rtl/red_pitaya_fads_cond.sv
// FADS conditioner: boxcar average, optional frozen-baseline subtraction, 14-bit saturation.
// Baseline tracking is built only when FADS_COND_BASELINE_EN is defined.
module red_pitaya_fads_cond
   import red_pitaya_fads_pkg::*;
#(
   parameter int AVG_LOG2_MAX = 4
)(
   input  logic                  adc_clk_i,
   input  logic                  adc_rst_i,
   input  logic signed [DWT-1:0] adc_a_i,
   output logic signed [DWT-1:0] cond_o,
   output logic                  cond_valid_o,
   red_pitaya_fads_cond_if.slave sys
);
   localparam int LW = $clog2(AVG_LOG2_MAX + 1);

   state_t                r_state, w_nxt;
   logic                  r_enable;
   logic [LW-1:0]         r_avg_log2;
   logic [31:0]           r_sat_cnt;
   logic [19:0]           w_addr;
   logic                  w_wr_ctrl, w_wr_avg, w_clear, w_en_nxt, w_flush, w_run;
   logic signed [DWT-1:0] w_avg, w_bl;
   logic signed [DWT:0]   w_d;
   logic                  w_filled;
   logic [31:0]           w_rdata;
   logic                  w_unused;

   assign w_addr    = sys.sys_addr[19:0];
   assign w_wr_ctrl = sys.sys_wen && (w_addr == REG_CTRL);
   assign w_wr_avg  = sys.sys_wen && (w_addr == REG_AVG);
   assign w_clear   = w_wr_ctrl && sys.sys_wdata[1];
   assign w_en_nxt  = w_wr_ctrl ? sys.sys_wdata[0] : r_enable;
   assign w_flush   = w_wr_avg || w_clear || (w_wr_ctrl && !sys.sys_wdata[0]);
   assign w_run     = w_filled && !w_flush;
   assign w_d       = (DWT+1)'(w_avg) - (DWT+1)'(w_bl);
   assign w_unused  = ^{sys.sys_sel, sys.sys_addr[31:20]};
   assign sys.sys_err = 1'b0;

   red_pitaya_fads_boxcar #(.AVG_LOG2_MAX(AVG_LOG2_MAX)) u_boxcar (
      .clk      (adc_clk_i),
      .rst      (adc_rst_i),
      .i_en     (r_state != IDLE),
      .i_flush  (w_flush),
      .i_log2   (r_avg_log2),
      .i_x      (adc_a_i),
      .o_avg    (w_avg),
      .o_filled (w_filled)
   );

   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) r_state <= IDLE;
      else           r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      if (!w_en_nxt)    w_nxt = IDLE;
      else if (w_flush) w_nxt = FILL;
      else begin
         case (r_state)
            IDLE:    w_nxt = FILL;
            FILL:    if (w_filled) w_nxt = RUN;
            default: ;
         endcase
      end
   end

`ifdef FADS_COND_BASELINE_EN
   localparam int BW = DWT + 16;
   logic [3:0]            r_bl_shift;
   logic signed [DWT-1:0] r_thr;
   logic signed [BW-1:0]  r_bl_acc;
   logic signed [BW:0]    w_err, w_step;
   logic                  w_frz, w_unused_bl;

   assign w_bl        = r_bl_acc[BW-1:16];
   assign w_frz       = (w_d >= (DWT+1)'(r_thr));
   assign w_err       = (BW+1)'($signed({w_avg, 16'h0000})) - (BW+1)'(r_bl_acc);
   assign w_step      = w_err >>> r_bl_shift;
   assign w_unused_bl = w_step[BW];

   // baseline holds while a droplet lifts the signal above the freeze threshold
   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i)             r_bl_acc <= '0;
      else if (w_clear)          r_bl_acc <= '0;
      else if (w_run && !w_frz)  r_bl_acc <= r_bl_acc + w_step[BW-1:0];
   end

   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) begin
         r_bl_shift <= 4'd10;
         r_thr      <= DWT'(64);
      end else if (sys.sys_wen) begin
         if (w_addr == REG_BLSH)
            r_bl_shift <= (sys.sys_wdata == 32'd0) ? 4'd1 :
                          (sys.sys_wdata > 32'd15) ? 4'd15 : sys.sys_wdata[3:0];
         if (w_addr == REG_THR) r_thr <= sys.sys_wdata[DWT-1:0];
      end
   end
`else
   assign w_bl = '0;
`endif

   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) begin
         r_enable   <= 1'b1;
         r_avg_log2 <= LW'(2);
      end else begin
         if (w_wr_ctrl) r_enable <= sys.sys_wdata[0];
         if (w_wr_avg)
            r_avg_log2 <= (sys.sys_wdata > 32'(AVG_LOG2_MAX)) ? LW'(AVG_LOG2_MAX)
                                                              : LW'(sys.sys_wdata);
      end
   end

   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i)    r_sat_cnt <= '0;
      else if (w_clear) r_sat_cnt <= '0;
      else if (w_run && is_clip(w_d) && (r_sat_cnt != '1)) r_sat_cnt <= r_sat_cnt + 32'd1;
   end

   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) begin
         cond_o       <= '0;
         cond_valid_o <= 1'b0;
      end else begin
         cond_o       <= (w_nxt == IDLE) ? '0 : sat(w_d);
         cond_valid_o <= w_run;
      end
   end

   always_comb begin
      w_rdata = '0;
      case (w_addr)
         REG_CTRL: w_rdata = {31'h0, r_enable};
         REG_AVG:  w_rdata = 32'(r_avg_log2);
`ifdef FADS_COND_BASELINE_EN
         REG_BLSH: w_rdata = 32'(r_bl_shift);
         REG_THR:  w_rdata = 32'(r_thr);
         REG_BL:   w_rdata = 32'(w_bl);
`endif
         REG_SAT:  w_rdata = r_sat_cnt;
         default:  ;
      endcase
   end

   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) begin
         sys.sys_ack   <= 1'b0;
         sys.sys_rdata <= '0;
      end else begin
         sys.sys_ack   <= sys.sys_wen || sys.sys_ren;
         sys.sys_rdata <= sys.sys_ren ? w_rdata : '0;
      end
   end

endmodule

// File: tb/tb_red_pitaya_fads_cond.sv
// Directed bench for red_pitaya_fads_cond; baseline checks compile in with FADS_COND_BASELINE_EN.
module tb_red_pitaya_fads_cond;

`ifdef FADS_COND_BASELINE_EN
   localparam bit BL = 1'b1;
`else
   localparam bit BL = 1'b0;
`endif

   logic               clk;
   logic               rst;
   logic signed [13:0] adc_a;
   logic signed [13:0] cond;
   logic               cond_v;
   int                 n_chk = 0;
   int                 n_err = 0;

   typedef struct {
      logic signed [13:0] x;
      int                 exp;
   } vec_t;
   vec_t tbl [25];

   red_pitaya_fads_cond_if bus ();

   red_pitaya_fads_cond dut (
      .adc_clk_i    (clk),
      .adc_rst_i    (rst),
      .adc_a_i      (adc_a),
      .cond_o       (cond),
      .cond_valid_o (cond_v),
      .sys          (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.sys_addr  = a;
      bus.sys_wdata = d;
      bus.sys_wen   = 1'b1;
      tick();
      bus.sys_wen   = 1'b0;
      chk("wr_ack", int'(bus.sys_ack), 1);
   endtask

   task automatic rd(input logic [31:0] a, output int d);
      bus.sys_addr = a;
      bus.sys_ren  = 1'b1;
      tick();
      bus.sys_ren  = 1'b0;
      chk("rd_ack", int'(bus.sys_ack), 1);
      d = int'(bus.sys_rdata);
   endtask

   initial begin
      int d;
      logic signed [13:0] xs [25] = '{400, 400, 400, 400, 400, 400, -400, -400, -400, -400,
                                      -400, -400, 0, 0, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0};
      int es [25] = '{0, 0, 100, 200, 300, 400, 400, 400, 200, 0, -200, -400, -400, -400,
                      -300, -200, -100, 0, 0, 0, -1, -1, -1, -1, 0};
      for (int i = 0; i < 25; i++) begin
         tbl[i].x   = xs[i];
         tbl[i].exp = es[i];
      end

      rst = 1'b1; adc_a = '0;
      bus.sys_addr = '0; bus.sys_wdata = '0; bus.sys_sel = 4'hF;
      bus.sys_wen = 1'b0; bus.sys_ren = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cond", int'(cond), 0);
      chk("rst_valid", int'(cond_v), 0);
      chk("rst_ack", int'(bus.sys_ack), 0);
      chk("rst_rdata", int'(bus.sys_rdata), 0);
      rst = 1'b0;

      rd(32'h00, d); chk("def_ctrl", d, 1);
      rd(32'h04, d); chk("def_avg", d, 2);
      rd(32'h08, d); chk("def_blsh", d, BL ? 10 : 0);
      rd(32'h0C, d); chk("def_thr", d, BL ? 64 : 0);
      rd(32'h10, d); chk("def_bl", d, 0);
      rd(32'h14, d); chk("def_sat", d, 0);
      rd(32'h30, d); chk("unmapped", d, 0);

      // park the baseline at 0 so the boxcar table holds in both builds
      wr(32'h0C, 32'h0000_2000);
      rd(32'h0C, d); chk("thr_rd", d, BL ? -8192 : 0);
      wr(32'h08, 32'd0);
      rd(32'h08, d); chk("blsh_zero", d, BL ? 1 : 0);
      wr(32'h0000_0000, 32'd3);
      adc_a = 14'sd0;
      repeat (10) tick();
      chk("pre_valid", int'(cond_v), 1);

      for (int i = 0; i < 25; i++) begin
         adc_a = tbl[i].x;
         tick();
         chk($sformatf("box[%0d]", i), int'(cond), tbl[i].exp);
      end

      // flush by avg_log2 write: valid drops, refills over 8 samples
      adc_a = 14'sd0;
      chk("flush_pre", int'(cond_v), 1);
      wr(32'h04, 32'd3);
      chk("flush_drop", int'(cond_v), 0);
      repeat (9) tick();
      chk("flush_w10", int'(cond_v), 0);
      tick();
      chk("flush_w11", int'(cond_v), 1);
      rd(32'h04, d); chk("avg_rd3", d, 3);
      wr(32'h04, 32'd9);
      rd(32'h04, d); chk("avg_clamp", d, 4);
      wr(32'h04, 32'd2);

      // disable then re-enable
      adc_a = 14'sd1000;
      wr(32'h00, 32'd0);
      chk("dis_valid", int'(cond_v), 0);
      chk("dis_cond", int'(cond), 0);
      repeat (3) tick();
      chk("idle_cond", int'(cond), 0);
      wr(32'h00, 32'd1);
      repeat (5) tick();
      chk("en_w6", int'(cond_v), 0);
      tick();
      chk("en_w7_valid", int'(cond_v), 1);
      chk("en_w7_cond", int'(cond), 1000);

      wr(32'h00, 32'd3);
      chk("clr_drop", int'(cond_v), 0);
      rd(32'h14, d); chk("clr_sat", d, 0);

`ifdef FADS_COND_BASELINE_EN
      // convergence
      wr(32'h0C, 32'h0000_1FFF);
      wr(32'h08, 32'd4);
      adc_a = 14'sd1000;
      repeat (2000) tick();
      chk("conv_cond", int'(cond >= -1 && cond <= 1), 1);
      rd(32'h10, d); chk("conv_bl", int'(d >= 999 && d <= 1000), 1);

      // saturation against a baseline near 8000
      adc_a = 14'sd8000;
      repeat (2000) tick();
      wr(32'h08, 32'd15);
      wr(32'h04, 32'd0);
      repeat (5) tick();
      rd(32'h14, d); chk("sat_pre", d, 0);
      for (int i = 0; i < 10; i++) begin
         adc_a = -14'sd8192;
         tick();
         if (i == 2 || i == 9) chk($sformatf("sat_cond[%0d]", i), int'(cond), -8192);
      end
      adc_a = 14'sd8000;
      repeat (10) tick();
      rd(32'h14, d); chk("sat_cnt", d, 10);
      wr(32'h00, 32'd3);
      rd(32'h14, d); chk("sat_clr", d, 0);
      rd(32'h10, d); chk("bl_clr", d, 0);

      // freeze
      wr(32'h0C, 32'd64);
      wr(32'h08, 32'd4);
      adc_a = 14'sd0;
      repeat (10) tick();
      adc_a = 14'sd2000;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (i >= 2) chk($sformatf("frz_cond[%0d]", i), int'(cond), 2000);
      end
      rd(32'h10, d); chk("frz_bl", d, 0);
      adc_a = 14'sd0;
      repeat (5) tick();
      chk("frz_back", int'(cond), 0);
`endif

      // asynchronous reset in the middle of RUN
      wr(32'h04, 32'd4);
      adc_a = 14'sd500;
      repeat (25) tick();
      chk("run_valid", int'(cond_v), 1);
      chk("run_cond", int'(cond), 500);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_cond", int'(cond), 0);
      chk("arst_valid", int'(cond_v), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rd(32'h00, d); chk("rst2_ctrl", d, 1);
      rd(32'h04, d); chk("rst2_avg", d, 2);
      rd(32'h08, d); chk("rst2_blsh", d, BL ? 10 : 0);
      rd(32'h0C, d); chk("rst2_thr", d, BL ? 64 : 0);
      rd(32'h14, d); chk("rst2_sat", d, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
